// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with ack handshake and a hold timeout.
// Emits the registered winner index and valid flag for a downstream 3-to-8 decoder.
module rr_arbiter_8 #(
    parameter int unsigned HOLD_W   = 4,
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_req,
    input  logic       i_gnt_ack,
    output logic [2:0] o_gnt_idx,
    output logic       o_gnt_valid,
    output logic       o_timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    // Counter value on which the timer forces a release; unused when MAX_HOLD is 0.
    localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HoldSat  = '1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [2:0]        r_gnt_idx;
    logic [2:0]        w_gnt_idx_nxt;
    logic [2:0]        r_ptr;
    logic [2:0]        w_ptr_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;

    logic              w_found;
    logic [2:0]        w_winner;
    logic [2:0]        w_cand;
    logic              w_drop;
    logic              w_tmr;
    logic              w_release;

    // First set request bit at or after the rotating pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_cand   = r_ptr;
        for (int i = 0; i < 8; i++) begin
            w_cand = r_ptr + 3'(i);
            if (!w_found && i_req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        w_drop    = !i_req[r_gnt_idx];
        w_tmr     = (MAX_HOLD != 0) && (r_hold_cnt == HoldLast);
        w_release = i_gnt_ack || w_drop || w_tmr;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_idx_nxt  = r_gnt_idx;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_timeout_nxt  = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_gnt_idx_nxt  = w_winner;
                    w_hold_cnt_nxt = '0;
                    w_state_nxt    = StGrant;
                end
            end
            StGrant: begin
                if (w_release) begin
                    w_state_nxt    = StIdle;
                    w_ptr_nxt      = r_gnt_idx + 3'd1;
                    w_hold_cnt_nxt = '0;
                    // Flag only releases the timer alone is responsible for.
                    w_timeout_nxt  = w_tmr && !i_gnt_ack && !w_drop;
                end else if (r_hold_cnt != HoldSat) begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_gnt_idx  <= 3'd0;
            r_ptr      <= 3'd0;
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt_idx  <= w_gnt_idx_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign o_gnt_idx   = r_gnt_idx;
    assign o_gnt_valid = (r_state == StGrant);
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios plus random traffic, all checked
// against a behavioural model of the grant/rotate/timeout rules.
module tb_rr_arbiter_8;

    localparam int MaxHold = 15;
    localparam int HoldSat = 15;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       gnt_ack;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_tests;
    int n_fail;

    // Reference model state
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_hold;
    bit m_to;

    rr_arbiter_8 #(
        .HOLD_W  (4),
        .MAX_HOLD(MaxHold)
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_gnt_ack  (gnt_ack),
        .o_gnt_idx  (gnt_idx),
        .o_gnt_valid(gnt_valid),
        .o_timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 1'b0;
        m_idx  = 0;
        m_ptr  = 0;
        m_hold = 0;
        m_to   = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic a);
        bit drop;
        bit tmr;
        bit found;
        if (!m_busy) begin
            m_to  = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (!found && r[c]) begin
                    found = 1'b1;
                    m_idx = c;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_hold = 0;
            end
        end else begin
            drop = !r[m_idx];
            tmr  = (MaxHold != 0) && (m_hold == MaxHold - 1);
            if (a || drop || tmr) begin
                m_busy = 1'b0;
                m_ptr  = (m_idx + 1) % 8;
                m_hold = 0;
                m_to   = tmr && !a && !drop;
            end else begin
                m_to = 1'b0;
                if (m_hold < HoldSat) m_hold++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        n_tests++;
        assert (gnt_valid === m_busy) else begin
            n_fail++;
            $error("FAIL %s gnt_valid got %b want %b", tag, gnt_valid, m_busy);
        end
        n_tests++;
        assert (gnt_idx === 3'(m_idx)) else begin
            n_fail++;
            $error("FAIL %s gnt_idx got %0d want %0d", tag, gnt_idx, m_idx);
        end
        n_tests++;
        assert (timeout === m_to) else begin
            n_fail++;
            $error("FAIL %s timeout got %b want %b", tag, timeout, m_to);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [2:0] idx,
                              input logic to);
        n_tests++;
        assert (gnt_valid === v) else begin
            n_fail++;
            $error("FAIL %s gnt_valid got %b want %b", tag, gnt_valid, v);
        end
        n_tests++;
        assert (gnt_idx === idx) else begin
            n_fail++;
            $error("FAIL %s gnt_idx got %0d want %0d", tag, gnt_idx, idx);
        end
        n_tests++;
        assert (timeout === to) else begin
            n_fail++;
            $error("FAIL %s timeout got %b want %b", tag, timeout, to);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic cycle(input logic [7:0] r, input logic a, input string tag);
        req     = r;
        gnt_ack = a;
        @(posedge clk);
        model_step(r, a);
        #1;
        check_model(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         hold_cycles;
        logic [7:0] rreq;
        logic       rack;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = 8'h00;
        gnt_ack = 1'b0;
        model_reset();

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        expect_out("in_reset", 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        repeat (5) cycle(8'h00, 1'b0, "idle");
        expect_out("idle_end", 1'b0, 3'd0, 1'b0);

        // Basic grant and rotation between 2 and 5
        cycle(8'b0010_0100, 1'b0, "rot_g2");
        expect_out("rot_first", 1'b1, 3'd2, 1'b0);
        cycle(8'b0010_0100, 1'b1, "rot_ack");
        expect_out("rot_gap", 1'b0, 3'd2, 1'b0);
        cycle(8'b0010_0100, 1'b0, "rot_g5");
        expect_out("rot_second", 1'b1, 3'd5, 1'b0);
        cycle(8'b0010_0100, 1'b1, "rot_ack");
        cycle(8'b0010_0100, 1'b0, "rot_g2b");
        expect_out("rot_third", 1'b1, 3'd2, 1'b0);
        cycle(8'b0010_0100, 1'b1, "rot_ack");
        cycle(8'b0010_0100, 1'b0, "rot_g5b");
        expect_out("rot_fourth", 1'b1, 3'd5, 1'b0);
        cycle(8'b0010_0100, 1'b1, "rot_ack");

        // Wrap-around: grant 7, then 0 before 7
        cycle(8'b1000_0000, 1'b0, "wrap_g7");
        expect_out("wrap_seven", 1'b1, 3'd7, 1'b0);
        cycle(8'b1000_0000, 1'b1, "wrap_ack");
        cycle(8'b1000_0001, 1'b0, "wrap_g0");
        expect_out("wrap_zero", 1'b1, 3'd0, 1'b0);
        cycle(8'b1000_0001, 1'b1, "wrap_ack");
        cycle(8'b1000_0001, 1'b0, "wrap_g7b");
        expect_out("wrap_seven_b", 1'b1, 3'd7, 1'b0);
        cycle(8'b1000_0001, 1'b1, "wrap_ack");

        // Release by dropping the request
        cycle(8'b0000_1000, 1'b0, "drop_g3");
        expect_out("drop_grant", 1'b1, 3'd3, 1'b0);
        cycle(8'b0000_0000, 1'b0, "drop_rel");
        expect_out("drop_release", 1'b0, 3'd3, 1'b0);

        // Hold timeout on requester 6
        cycle(8'b0100_0000, 1'b0, "to_g6");
        hold_cycles = 1;
        for (int i = 0; i < 40; i++) begin
            cycle(8'b0100_0000, 1'b0, "to_hold");
            if (!gnt_valid) break;
            hold_cycles++;
        end
        n_tests++;
        assert (hold_cycles == 15) else begin
            n_fail++;
            $error("FAIL to_len valid cycles got %0d want 15", hold_cycles);
        end
        expect_out("to_pulse", 1'b0, 3'd6, 1'b1);
        cycle(8'b0100_0000, 1'b0, "to_regrant");
        expect_out("to_regrant", 1'b1, 3'd6, 1'b0);
        cycle(8'b0000_0000, 1'b1, "to_ack");

        // Ack, drop and timer expiry together: single release without timeout
        cycle(8'b0000_0010, 1'b0, "sim_g1");
        repeat (14) cycle(8'b0000_0010, 1'b0, "sim_hold");
        cycle(8'b0000_0000, 1'b1, "sim_rel");
        expect_out("sim_release", 1'b0, 3'd1, 1'b0);

        // Ack while idle is ignored
        cycle(8'b0000_0000, 1'b1, "idle_ack");
        expect_out("idle_ack", 1'b0, 3'd1, 1'b0);

        // Async reset mid-grant at index 4
        cycle(8'b0001_0000, 1'b0, "ar_g4");
        expect_out("ar_grant", 1'b1, 3'd4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("ar_async", 1'b0, 3'd0, 1'b0);
        model_reset();
        req = 8'b0001_0001;
        @(posedge clk);
        #1;
        expect_out("ar_held", 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        cycle(8'b0001_0001, 1'b0, "ar_post");
        expect_out("ar_post", 1'b1, 3'd0, 1'b0);
        cycle(8'b0001_0001, 1'b1, "ar_ack");

        // Random traffic with sticky requests so timeouts and drops both occur
        rreq = 8'($urandom);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) rreq = 8'($urandom) & 8'($urandom);
            rack = ($urandom_range(5) == 0);
            cycle(rreq, rack, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- 8-requester round-robin arbiter with a grant/acknowledge handshake.
- Outputs the winning requester as a registered 3-bit index plus a valid flag.
- Sits directly upstream of the 3-to-8 decoder, which expands gnt_idx into the one-hot grant bus for the requesters.
- A hold-timeout guarantees a stuck requester cannot block the bus indefinitely.

Parameters:
- HOLD_W, 4, width of the grant-hold cycle counter.
- MAX_HOLD, 15, maximum cycles a grant may stay asserted without ack before forced release. 0 disables the timeout. Must be ≤ 2^HOLD_W − 1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i = requester i wants the resource.
- gnt_ack  input  1  consumer/requester finished; releases the current grant.
- gnt_idx  output  3  index of the granted requester; feeds the decoder input.
- gnt_valid  output  1  high while gnt_idx holds a live grant.
- timeout  output  1  one-cycle pulse when a grant is force-released by the hold timer.

Behaviour:
- Reset (async assert, any time, including mid-grant):
  - gnt_idx=3'b000, gnt_valid=0, timeout=0.
  - ptr=3'd0, hold_cnt=0, state=IDLE.
  - Deassertion is sampled synchronously; the first arbitration can occur on the first rising edge after rst_n goes high.
- State IDLE:
  - If req==0 at a rising edge: stay IDLE, outputs unchanged, gnt_valid=0.
  - If req!=0: choose the first set bit searching ptr, ptr+1, …, ptr+7 (mod 8).
  - Register the winner in gnt_idx, set gnt_valid=1, clear hold_cnt, go to GRANT.
  - Latency: req seen at edge N → gnt_valid/gnt_idx valid immediately after edge N (one register stage).
- State GRANT:
  - gnt_idx is frozen while gnt_valid=1. Changes to other req bits are ignored.
  - Release condition at an edge: gnt_ack=1, OR req[gnt_idx]=0, OR (MAX_HOLD≠0 AND hold_cnt==MAX_HOLD−1).
  - On release:
    - gnt_valid←0.
    - ptr←gnt_idx+1 (3-bit wrap, 7→0).
    - hold_cnt←0.
    - state←IDLE.
    - gnt_idx keeps its last value.
  - timeout←1 for exactly one cycle only when the release is caused solely by the timer (neither gnt_ack nor a dropped req in the same cycle). Otherwise timeout=0.
  - If no release, hold_cnt increments, saturating at 2^HOLD_W−1.
- Simultaneous events:
  - ack + req drop + timer expiry in one cycle: a single release, timeout=0.
  - gnt_ack while gnt_valid=0 is ignored.
- Throughput: a mandatory one-cycle IDLE gap follows every release. Back-to-back grants are spaced at least 2 cycles.
- Fairness: a requester that holds req high is granted within 7 intervening grants.

Test Plan:
- Reset/idle: hold rst_n=0, then release with req=0 for 5 cycles → gnt_valid=0, gnt_idx=000, timeout=0 throughout.
- Basic grant and rotation:
  - Stimulus: req=8'b0010_0100 from reset; pulse gnt_ack one cycle after each grant.
  - Required grant sequence: gnt_idx=2, 5, 2, 5.
  - gnt_valid is high one cycle after each request edge, with a 1-cycle low gap between grants.
- Wrap-around: after a grant to idx 7 is acked, apply req=8'b1000_0001 → next gnt_idx=0 (ptr wrapped to 0), then 7 after ack.
- Req drop release: grant idx 3 with req=8'b0000_1000, then clear req[3] with gnt_ack=0 → gnt_valid falls after that edge, timeout=0.
- Timeout: MAX_HOLD=15, req=8'b0100_0000 held, gnt_ack=0 → gnt_valid high exactly 15 cycles, timeout pulses for 1 cycle, ptr=7. Regrant to idx 6 occurs after the 1-cycle gap.
- Async reset mid-grant: assert rst_n=0 between edges while gnt_valid=1 at idx 4 → gnt_valid=0, gnt_idx=000 immediately without a clock edge. After release with req=8'b0001_0001 → gnt_idx=0.
